spi_sd_responder: RTL

- Downstream of the SPI command receiver in the SD-card-over-SPI emulator.
- Consumes each decoded command (6-bit index plus 32-bit argument) and keeps the card-state registers: idle, app-command and block length.
- Produces the SD response byte stream (R1, R7, optional R3) for the SPI output shifter, one byte per shifter request.

---
 rtl/spi_sd_responder.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_sd_responder.sv
// spi_sd_responder
//
// Card-state keeper and response byte generator for the SD-over-SPI emulator.
// Each rising edge of io_CommandReadFinished decodes one command and updates
// the card state (idle, app-command, block length) in that same cycle. The
// response bytes are then offered on io_TxByte: NCR_BYTES 0xFF filler bytes,
// the R1 byte, and an optional 4-byte payload (R7 for CMD8, R3 for CMD58).
// The output shifter advances the stream with a one-cycle io_ByteRequest.
//
// Optional feature: define SPI_SD_RESP_CMD58_EN to answer CMD58 with an R3
// (OCR) payload. With the macro undefined, CMD58 is treated as illegal.
//
// Ports:
//   clock                   system clock
//   reset                   synchronous, active-high reset
//   io_CommandReadFinished  level, command/argument valid; rising edge acted on
//   io_Command              6-bit command index
//   io_CommandArgument      32-bit command argument
//   io_ByteRequest          one-cycle pulse, consumes io_TxByte
//   io_TxByte               byte currently offered to the shifter (registered)
//   io_Busy                 response sequence pending (registered)
//   io_IdleState            card idle flag, R1 bit0
//   io_AppCmd               next command is an ACMD
//   io_BlockLength          current block length

module spi_sd_responder #(
    parameter int unsigned NCR_BYTES       = 1,
    parameter int unsigned MAX_BLOCK_LEN   = 2048,
    parameter int unsigned RESET_BLOCK_LEN = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_CommandReadFinished,
    input  logic [5:0]  io_Command,
    input  logic [31:0] io_CommandArgument,
    input  logic        io_ByteRequest,
    output logic [7:0]  io_TxByte,
    output logic        io_Busy,
    output logic        io_IdleState,
    output logic        io_AppCmd,
    output logic [11:0] io_BlockLength
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_NCR     = 2'd1;
    localparam logic [1:0] ST_R1      = 2'd2;
    localparam logic [1:0] ST_PAYLOAD = 2'd3;

    // Filler counter value at which the next request moves on to R1.
    localparam logic [2:0]  NCR_LAST  = 3'(NCR_BYTES - 1);
    localparam logic [11:0] BLK_RESET = 12'(RESET_BLOCK_LEN);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        cmd_finished_q;
    logic [1:0]  state_q,       state_d;
    logic [2:0]  ncr_cnt_q,     ncr_cnt_d;
    logic [1:0]  pl_idx_q,      pl_idx_d;
    logic [7:0]  r1_q,          r1_d;
    logic [31:0] payload_q,     payload_d;
    logic        has_payload_q, has_payload_d;
    logic [7:0]  tx_byte_q,     tx_byte_d;
    logic        busy_q,        busy_d;
    logic        idle_q,        idle_d;
    logic        app_cmd_q,     app_cmd_d;
    logic [11:0] block_len_q,   block_len_d;

    logic start;
    assign start = io_CommandReadFinished & ~cmd_finished_q;

    // ------------------------------------------------------------------
    // Command decode (only consumed in the start cycle)
    // ------------------------------------------------------------------
    logic        dec_idle;
    logic        dec_app;
    logic [11:0] dec_blk;
    logic        dec_illegal;
    logic        dec_param_err;
    logic        dec_has_payload;
    logic [31:0] dec_payload;
    logic [7:0]  dec_r1;
    logic [3:0]  vhs;

    // Only the 2.7-3.6 V range (VHS=1) is echoed back; anything else reads as 0.
    assign vhs = (io_CommandArgument[11:8] == 4'h1) ? 4'h1 : 4'h0;

    always_comb begin
        dec_idle        = idle_q;
        dec_app         = 1'b0;       // every command except CMD55 clears it
        dec_blk         = block_len_q;
        dec_illegal     = 1'b0;
        dec_param_err   = 1'b0;
        dec_has_payload = 1'b0;
        dec_payload     = 32'h0;

        case (io_Command)
            6'd0: begin
                dec_idle = 1'b1;
            end
            6'd8: begin
                dec_has_payload = 1'b1;
                dec_payload     = {16'h0000, 4'h0, vhs, io_CommandArgument[7:0]};
            end
            6'd55: begin
                dec_app = 1'b1;
            end
            6'd41: begin
                if (app_cmd_q) begin
                    dec_idle = 1'b0;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            6'd16: begin
                // Full 32-bit range check so large arguments never alias into 12 bits.
                if ((io_CommandArgument >= 32'd1) && (io_CommandArgument <= MAX_BLOCK_LEN)) begin
                    dec_blk = io_CommandArgument[11:0];
                end else begin
                    dec_param_err = 1'b1;
                end
            end
`ifdef SPI_SD_RESP_CMD58_EN
            6'd58: begin
                // OCR: bit31 power-up done, bit30 CCS, full voltage window.
                dec_has_payload = 1'b1;
                dec_payload     = {~idle_q, 1'b1, 6'h3F, 8'hFF, 8'h80, 8'h00};
            end
`endif
            default: begin
                dec_illegal = 1'b1;
            end
        endcase

        dec_r1 = {1'b0, dec_param_err, 3'b000, dec_illegal, 1'b0, dec_idle};
    end

    // ------------------------------------------------------------------
    // Response sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        ncr_cnt_d     = ncr_cnt_q;
        pl_idx_d      = pl_idx_q;
        r1_d          = r1_q;
        payload_d     = payload_q;
        has_payload_d = has_payload_q;
        idle_d        = idle_q;
        app_cmd_d     = app_cmd_q;
        block_len_d   = block_len_q;

        if (start) begin
            // A new command always wins: any request this cycle is dropped and
            // an in-flight response is abandoned.
            state_d       = ST_NCR;
            ncr_cnt_d     = 3'd0;
            pl_idx_d      = 2'd0;
            r1_d          = dec_r1;
            payload_d     = dec_payload;
            has_payload_d = dec_has_payload;
            idle_d        = dec_idle;
            app_cmd_d     = dec_app;
            block_len_d   = dec_blk;
        end else if (io_ByteRequest) begin
            case (state_q)
                ST_NCR: begin
                    ncr_cnt_d = ncr_cnt_q + 3'd1;
                    if (ncr_cnt_q == NCR_LAST) begin
                        state_d = ST_R1;
                    end
                end
                ST_R1: begin
                    pl_idx_d = 2'd0;
                    state_d  = has_payload_q ? ST_PAYLOAD : ST_IDLE;
                end
                ST_PAYLOAD: begin
                    if (pl_idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end else begin
                        pl_idx_d = pl_idx_q + 2'd1;
                    end
                end
                default: begin
                    // Requests while idle are ignored.
                end
            endcase
        end
    end

    // Outputs are registered: derive them from the next state.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_R1: begin
                tx_byte_d = r1_d;
            end
            ST_PAYLOAD: begin
                case (pl_idx_d)
                    2'd0:    tx_byte_d = payload_d[31:24];
                    2'd1:    tx_byte_d = payload_d[23:16];
                    2'd2:    tx_byte_d = payload_d[15:8];
                    default: tx_byte_d = payload_d[7:0];
                endcase
            end
            default: begin
                tx_byte_d = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_finished_q <= 1'b0;
            state_q        <= ST_IDLE;
            ncr_cnt_q      <= 3'd0;
            pl_idx_q       <= 2'd0;
            r1_q           <= 8'h00;
            payload_q      <= 32'h0;
            has_payload_q  <= 1'b0;
            tx_byte_q      <= 8'hFF;
            busy_q         <= 1'b0;
            idle_q         <= 1'b1;
            app_cmd_q      <= 1'b0;
            block_len_q    <= BLK_RESET;
        end else begin
            cmd_finished_q <= io_CommandReadFinished;
            state_q        <= state_d;
            ncr_cnt_q      <= ncr_cnt_d;
            pl_idx_q       <= pl_idx_d;
            r1_q           <= r1_d;
            payload_q      <= payload_d;
            has_payload_q  <= has_payload_d;
            tx_byte_q      <= tx_byte_d;
            busy_q         <= busy_d;
            idle_q         <= idle_d;
            app_cmd_q      <= app_cmd_d;
            block_len_q    <= block_len_d;
        end
    end

    assign io_TxByte      = tx_byte_q;
    assign io_Busy        = busy_q;
    assign io_IdleState   = idle_q;
    assign io_AppCmd      = app_cmd_q;
    assign io_BlockLength = block_len_q;

endmodule
